// File: rtl/data_register.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : data_register
// Brief    : CPU data register; captures DATA_IN on LOAD, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module data_register #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             REST,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             LOAD,
    output logic [WIDTH-1:0] DATA_OUT
);

    logic [WIDTH-1:0] r_data;

    // Reset wins over any load on a coincident edge.
    always_ff @(posedge clk or negedge REST) begin
        if (!REST) begin
            r_data <= RESET_VALUE;
        end else if (LOAD) begin
            r_data <= DATA_IN;
        end
    end

    assign DATA_OUT = r_data;

endmodule
`default_nettype wire

// File: tb/tb_data_register.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for data_register: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural expectation.
module tb_data_register;

    localparam int          W  = 16;
    localparam logic [W-1:0] RV = '0;

    logic         clk = 1'b0;
    logic         REST;
    logic         LOAD;
    logic [W-1:0] DATA_IN;
    logic [W-1:0] DATA_OUT;

    int total = 0;
    int bad   = 0;

    // Behavioural expectation: what the register must hold right now.
    logic [W-1:0] exp_q     = '0;
    bit           exp_valid = 1'b0;

    data_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
        .clk      (clk),
        .REST     (REST),
        .DATA_IN  (DATA_IN),
        .LOAD     (LOAD),
        .DATA_OUT (DATA_OUT)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Per-cycle comparison, away from the rising edge.
    always @(negedge clk) begin
        if (exp_valid) check("model", DATA_OUT, exp_q);
    end

    // Drive inputs for the coming edge, then step to 1ns after it.
    task automatic tick(input logic r, input logic l, input logic [W-1:0] d);
        REST    = r;
        LOAD    = l;
        DATA_IN = d;
        if (!r) begin
            exp_q     = RV;
            exp_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if (r && l) begin
            exp_q     = d;
            exp_valid = 1'b1;
        end
    endtask

    // Drop reset in the middle of the clock-high phase and look 1ns later.
    task automatic async_reset(input string name);
        #1;
        REST      = 1'b0;
        exp_q     = RV;
        exp_valid = 1'b1;
        #1;
        check(name, DATA_OUT, 16'h0000);
    endtask

    initial begin
        REST    = 1'b1;
        LOAD    = 1'b0;
        DATA_IN = '0;
        @(posedge clk);
        #1;

        // Preload all ones, then reset asynchronously.
        tick(1'b1, 1'b1, 16'hFFFF);
        check("preload_ffff", DATA_OUT, 16'hFFFF);
        async_reset("async_rst_from_ffff");

        // Held in reset: loads ignored.
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, 16'h1234);
            check("rst_hold_load", DATA_OUT, 16'h0000);
        end

        // Released, load disabled.
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 16'h0015);
            check("hold_no_load", DATA_OUT, 16'h0000);
        end

        // Single load then hold.
        tick(1'b1, 1'b1, 16'h0015);
        check("single_load", DATA_OUT, 16'h0015);
        tick(1'b1, 1'b0, 16'hBEEF);
        check("hold_after_load", DATA_OUT, 16'h0015);
        tick(1'b1, 1'b0, 16'hBEEF);
        check("hold_after_load2", DATA_OUT, 16'h0015);

        // Back-to-back loads.
        tick(1'b1, 1'b1, 16'h0001);
        check("b2b_0001", DATA_OUT, 16'h0001);
        tick(1'b1, 1'b1, 16'h8000);
        check("b2b_8000", DATA_OUT, 16'h8000);
        tick(1'b1, 1'b1, 16'hFFFF);
        check("b2b_ffff", DATA_OUT, 16'hFFFF);

        // Reset coincident with load.
        tick(1'b0, 1'b1, 16'hA5A5);
        check("rst_priority", DATA_OUT, 16'h0000);
        tick(1'b1, 1'b0, 16'hA5A5);
        check("release_no_change", DATA_OUT, 16'h0000);
        tick(1'b1, 1'b1, 16'hA5A5);
        check("load_after_release", DATA_OUT, 16'hA5A5);

        // Async reset from 5A5A mid high phase.
        tick(1'b1, 1'b1, 16'h5A5A);
        check("load_5a5a", DATA_OUT, 16'h5A5A);
        async_reset("async_rst_from_5a5a");
        tick(1'b1, 1'b0, 16'h7777);
        check("after_async_rst", DATA_OUT, 16'h0000);

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 15) != 0), 1'($urandom_range(0, 1)), W'($urandom));
            if ($urandom_range(0, 24) == 0) begin
                async_reset("rand_async_rst");
                #1;
                REST = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_register.md
Name: data_register

Overview:
- General-purpose data register (DR) of the von Neumann CPU datapath.
- Holds one memory word between the memory/bus and the ALU.
- Captures DATA_IN on a clock edge when LOAD is asserted; otherwise holds its value.
- Drives its stored value continuously on DATA_OUT.

Parameters:
- WIDTH, 16, data word width in bits (CPU word size).
- RESET_VALUE, 0 (WIDTH bits), value forced into the register while reset is asserted.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- REST  input  1  asynchronous active-low reset; 0 = reset asserted, 1 = normal operation.
- DATA_IN  input  WIDTH (16)  word to be captured.
- LOAD  input  1  synchronous load enable, active-high.
- DATA_OUT  output  WIDTH (16)  current register contents.

Behaviour:
- Interface rule (already decided): one clock, clk; reset REST is asynchronous and active-low.
- Storage: a single WIDTH-bit register. DATA_OUT is driven directly by the register, with no combinational path from DATA_IN or LOAD.
- Reset:
  - On the falling edge of REST, the register becomes RESET_VALUE immediately, independent of clk.
  - While REST=0, the register stays at RESET_VALUE. Clock edges and LOAD are ignored.
  - The register is undefined after power-up until the first reset or load. Benches must apply reset before checking DATA_OUT.
- Reset release: REST 0->1 changes nothing by itself. The first capture can occur on the next rising clk edge with LOAD=1.
- Load:
  - On a rising clk edge with REST=1 and LOAD=1, the register takes DATA_IN.
  - DATA_OUT shows the new value after that edge, so latency is 1 clock.
- Hold: on a rising clk edge with REST=1 and LOAD=0, the register keeps its value. DATA_IN changes while LOAD=0 have no effect.
- Back-to-back loads: LOAD held high captures DATA_IN on every rising edge. Consecutive edges yield consecutive words, with no bubble.
- Simultaneous events:
  - Reset dominates: REST=0 coincident with a rising edge and LOAD=1 gives RESET_VALUE.
  - Reset asserted mid-operation discards any pending load.
- Width: full-width capture, no sign extension, truncation or arithmetic. All WIDTH bits are stored and driven unchanged.
- No X-propagation masking. Inputs are sampled only at the rising edge.

Test Plan:
- Reset: REST=0 with DATA_OUT previously 16'hFFFF -> DATA_OUT=16'h0000 before the next clk edge (asynchronous). It stays 0 across 3 edges with LOAD=1, DATA_IN=16'h1234.
- Hold with load disabled: after reset, REST=1, LOAD=0, DATA_IN=16'h0015 for 5 cycles -> DATA_OUT remains 16'h0000.
- Single load: REST=1, DATA_IN=16'h0015, LOAD=1 for one rising edge, then LOAD=0 and DATA_IN=16'hBEEF -> DATA_OUT=16'h0015 after that edge and holds 16'h0015 afterwards.
- Back-to-back loads: LOAD=1 on consecutive edges with DATA_IN=16'h0001, 16'h8000, 16'hFFFF -> DATA_OUT follows one cycle later with 16'h0001, 16'h8000, 16'hFFFF. All bits, including the MSB, are preserved.
- Reset priority: REST driven 0 in the same cycle as LOAD=1 with DATA_IN=16'hA5A5 -> DATA_OUT=16'h0000. After REST=1 with LOAD=0, it stays 0. The next LOAD=1 edge captures 16'hA5A5.
- Async timing: assert REST=0 mid clock-high phase while holding 16'h5A5A -> DATA_OUT goes to 0 within the same simulation time step, not at the next edge.
